// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-path definitions: widths, reset PC, FSM encoding and buffer entry layout.
package pc_fetch_unit_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned FETCH_DEPTH = 2;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read port plus fetch-to-decode handshake.
interface pc_fetch_unit_if;
    import pc_fetch_unit_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic               if_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );

endinterface

// File: rtl/pc_fetch_unit_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {instr, pc}; flush has priority over push/pop.
module pc_fetch_unit_fetch_fifo
    import pc_fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = FETCH_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = next_ptr(wr_q);
            end
            if (do_pop) begin
                rd_d = next_ptr(rd_q);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner: issues in-order imem reads, buffers returned words for decode,
// and drops responses that belong to the path abandoned by a redirect.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PC_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    pc_fetch_unit_if.master   bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  kill_q, kill_d;
    logic [ADDR_W-1:0] tag_q [DEPTH];
    logic [ADDR_W-1:0] tag_d [DEPTH];
    logic [PTR_W-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic              grant, rsp, push, pop;
    logic [CNT_W:0]    inflight;
    fetch_entry_t      fifo_din, fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_tgt_bits;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign unused_tgt_bits = ^branch_target[1:0];

    // Requests are capped so every response is guaranteed a buffer slot.
    assign inflight      = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign bus.imem_req  = (state_q == ST_FETCH) && !PC_sel && (inflight < DEPTH_L);
    assign bus.imem_addr = pc_q;

    assign grant = bus.imem_req && bus.imem_gnt;
    assign rsp   = bus.imem_rvalid;
    assign push  = rsp && (kill_q == '0) && !PC_sel;
    assign pop   = bus.if_valid && bus.if_ready && !PC_sel;

    assign fifo_din.instr = bus.imem_rdata;
    assign fifo_din.pc    = tag_q[tag_rd_q];

    assign bus.if_valid = !fifo_empty;
    assign bus.if_instr = fifo_dout.instr;
    assign bus.if_pc    = fifo_dout.pc;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp);
        kill_d        = kill_q;
        tag_d         = tag_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;

        unique case (state_q)
            ST_BOOT:   state_d = ST_FETCH;
            ST_FETCH:  if (halt) state_d = ST_HALTED;
            ST_HALTED: if (!halt) state_d = ST_FETCH;
            default:   state_d = ST_BOOT;
        endcase

        if (PC_sel) begin
            pc_d = align_word(branch_target);
        end else if (grant) begin
            pc_d = pc_q + PC_STEP;
        end

        // On redirect every response still in flight after this cycle is wrong-path.
        if (PC_sel) begin
            kill_d = outstanding_q - CNT_W'(rsp);
        end else if (rsp && (kill_q != '0)) begin
            kill_d = kill_q - CNT_W'(1);
        end

        if (grant) begin
            tag_d[tag_wr_q] = pc_q;
            tag_wr_d        = next_ptr(tag_wr_q);
        end
        if (rsp) begin
            tag_rd_d = next_ptr(tag_rd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    pc_fetch_unit_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (PC_sel),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_rsp_without_req: assert property (@(posedge clk) disable iff (reset)
        !(rsp && (outstanding_q == '0)));
    a_push_into_full: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with an in-order, one-cycle-latency imem model.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_sel;
    logic        halt;
    logic [31:0] branch_target;
    logic        rsp_hold;

    int checks   = 0;
    int failures = 0;
    int grants   = 0;

    logic [31:0] pend[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .PC_sel        (PC_sel),
        .branch_target (branch_target),
        .halt          (halt),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA500_0013;
    endfunction

    function automatic logic [31:0] pc_at(input int i);
        return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] instr_at(input int i);
        return (i < got_instr.size()) ? got_instr[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: sample handshakes before the edge, advance the memory model after it.
    task automatic tick();
        logic        g, r, p;
        logic [31:0] ga;
        #1;
        g  = bus.imem_req && bus.imem_gnt;
        ga = bus.imem_addr;
        r  = bus.imem_rvalid;
        p  = bus.if_valid && bus.if_ready && !PC_sel;
        if (p) begin
            got_pc.push_back(bus.if_pc);
            got_instr.push_back(bus.if_instr);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            pend.delete();
        end else begin
            if (r && pend.size() > 0) void'(pend.pop_front());
            if (g) begin
                pend.push_back(ga);
                grants++;
            end
        end
        bus.imem_rvalid = !rsp_hold && !reset && (pend.size() > 0);
        bus.imem_rdata  = (pend.size() > 0) ? mem_word(pend[0]) : 32'h0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        PC_sel           = 1'b0;
        halt             = 1'b0;
        branch_target    = 32'h0;
        rsp_hold         = 1'b0;
        bus.imem_gnt     = 1'b0;
        bus.if_ready     = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        grants = 0;
        got_pc.delete();
        got_instr.delete();
    endtask

    initial begin
        reset           = 1'b1;
        PC_sel          = 1'b0;
        halt            = 1'b0;
        branch_target   = 32'h0;
        rsp_hold        = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.if_ready    = 1'b0;

        // 1: streaming fetch from reset
        do_reset();
        settle();
        check("t1_boot_req", 32'(bus.imem_req), 32'd0);
        check("t1_boot_valid", 32'(bus.if_valid), 32'd0);
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        tick();
        settle();
        check("t1_req", 32'(bus.imem_req), 32'd1);
        check("t1_addr0", bus.imem_addr, 32'h0);
        tick();
        settle();
        check("t1_latency_valid", 32'(bus.if_valid), 32'd0);
        check("t1_addr1", bus.imem_addr, 32'h4);
        tick();
        settle();
        check("t1_first_valid", 32'(bus.if_valid), 32'd1);
        check("t1_head_pc", bus.if_pc, 32'h0);
        check("t1_cap_req", 32'(bus.imem_req), 32'd0);
        run(12);
        check("t1_pc0", pc_at(0), 32'h0);
        check("t1_pc1", pc_at(1), 32'h4);
        check("t1_pc2", pc_at(2), 32'h8);
        check("t1_pc3", pc_at(3), 32'hC);
        check("t1_instr2", instr_at(2), mem_word(32'h8));

        // 2: decode stalled, buffer fills, then resumes
        do_reset();
        bus.imem_gnt = 1'b1;
        run(12);
        check("t2_grants", 32'(grants), 32'd2);
        check("t2_req_dropped", 32'(bus.imem_req), 32'd0);
        check("t2_hold_pc", bus.if_pc, 32'h0);
        bus.if_ready = 1'b1;
        tick();
        settle();
        check("t2_next_head", bus.if_pc, 32'h4);
        check("t2_resume_req", 32'(bus.imem_req), 32'd1);
        check("t2_resume_addr", bus.imem_addr, 32'h8);
        run(8);
        check("t2_pc1", pc_at(1), 32'h4);
        check("t2_pc2", pc_at(2), 32'h8);

        // 3: redirect with two wrong-path reads in flight
        do_reset();
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        run(3);
        bus.imem_gnt = 1'b0;
        run(4);
        check("t3_drained", 32'(got_pc.size()), 32'd2);
        rsp_hold     = 1'b1;
        bus.imem_gnt = 1'b1;
        run(2);
        bus.imem_gnt = 1'b0;
        settle();
        check("t3_cap_req", 32'(bus.imem_req), 32'd0);
        PC_sel        = 1'b1;
        branch_target = 32'h100;
        settle();
        check("t3_redirect_req", 32'(bus.imem_req), 32'd0);
        tick();
        PC_sel       = 1'b0;
        rsp_hold     = 1'b0;
        bus.imem_gnt = 1'b1;
        run(10);
        check("t3_pc_after", pc_at(2), 32'h100);
        check("t3_instr_after", instr_at(2), mem_word(32'h100));
        check("t3_pc_next", pc_at(3), 32'h104);

        // 4: redirect coinciding with a response, misaligned target
        do_reset();
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        run(2);
        PC_sel        = 1'b1;
        branch_target = 32'h203;
        settle();
        check("t4_redirect_req", 32'(bus.imem_req), 32'd0);
        tick();
        PC_sel = 1'b0;
        settle();
        check("t4_addr", bus.imem_addr, 32'h200);
        check("t4_req", 32'(bus.imem_req), 32'd1);
        check("t4_dropped", 32'(bus.if_valid), 32'd0);
        run(6);
        check("t4_pc0", pc_at(0), 32'h200);
        check("t4_instr0", instr_at(0), mem_word(32'h200));

        // 5: halt mid-stream
        do_reset();
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        run(2);
        halt = 1'b1;
        run(9);
        check("t5_grants", 32'(grants), 32'd2);
        check("t5_halt_req", 32'(bus.imem_req), 32'd0);
        check("t5_inflight_pc", pc_at(1), 32'h4);
        halt = 1'b0;
        settle();
        check("t5_unhalt_req0", 32'(bus.imem_req), 32'd0);
        tick();
        settle();
        check("t5_resume_req", 32'(bus.imem_req), 32'd1);
        check("t5_resume_addr", bus.imem_addr, 32'h8);
        run(6);
        check("t5_pc2", pc_at(2), 32'h8);

        // 6: grant stall, then reset mid-stream
        do_reset();
        bus.if_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t6_stall_req", 32'(bus.imem_req), 32'd1);
            check("t6_stall_addr", bus.imem_addr, 32'h0);
            tick();
        end
        bus.imem_gnt = 1'b1;
        run(6);
        reset = 1'b1;
        tick();
        settle();
        check("t6_rst_req", 32'(bus.imem_req), 32'd0);
        check("t6_rst_valid", 32'(bus.if_valid), 32'd0);
        reset = 1'b0;
        got_pc.delete();
        got_instr.delete();
        settle();
        check("t6_boot_req", 32'(bus.imem_req), 32'd0);
        tick();
        settle();
        check("t6_restart_addr", bus.imem_addr, 32'h0);
        check("t6_restart_req", 32'(bus.imem_req), 32'd1);
        run(6);
        check("t6_pc0", pc_at(0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
